// File: rtl/uart_controller_if.sv
// Bus-side signals of the UART register window (DATA at address[2]=0, STATUS at address[2]=1).
// The decoder/CPU side takes the master modport, uart_controller takes the slave modport.
interface uart_controller_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] data_wr;
   logic [3:0]  mask;
   logic        stall;
   logic [31:0] data_rd;
   logic [31:0] data_rd_2;

   modport master (
      output address, read, write, data_wr, mask,
      input  stall, data_rd, data_rd_2
   );

   modport slave (
      input  address, read, write, data_wr, mask,
      output stall, data_rd, data_rd_2
   );
endinterface

// File: rtl/uart_controller.sv
// UART register window: TX/RX byte FIFOs plus 8N1 serializer and deserializer.
// Both directions run at a fixed CLK_DIV clocks per bit.
module uart_controller #(
   parameter int CLK_DIV  = 434,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   uart_controller_if.slave bus,
   output logic             txd,
   input  logic             rxd
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_CW = TX_AW + 1;
   localparam int RX_CW = RX_AW + 1;
   localparam int CNT_W = $clog2(CLK_DIV);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [7:0]       tx_mem_q [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
   logic [TX_CW-1:0] tx_count_q;
   logic             tx_full, tx_empty, tx_push, tx_pop;

   logic [1:0]       tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             txd_q, txd_d;

   logic [7:0]       rx_mem_q [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
   logic [RX_CW-1:0] rx_count_q;
   logic             rx_full, rx_empty, rx_push, rx_pop, rx_push_req;

   logic [1:0]       rx_sync_q;
   logic             rs;
   logic [1:0]       rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_armed_q, rx_armed_d;

   logic overrun_q, frame_err_q, set_overrun, set_frame_err, status_rd;
   logic unused_bus_bits;

   assign unused_bus_bits = ^{bus.address[31:3], bus.address[1:0], bus.data_wr[31:8], bus.mask[3:1]};

   assign tx_full   = (tx_count_q == TX_CW'(TX_DEPTH));
   assign tx_empty  = (tx_count_q == '0);
   assign rx_full   = (rx_count_q == RX_CW'(RX_DEPTH));
   assign rx_empty  = (rx_count_q == '0);
   assign tx_push   = bus.write && !bus.address[2] && bus.mask[0] && !tx_full;
   assign rx_pop    = bus.read && !bus.address[2] && !rx_empty;
   assign status_rd = bus.read && bus.address[2];

   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign rx_push     = rx_push_req && (!rx_full || rx_pop);
   assign set_overrun = rx_push_req && rx_full && !rx_pop;

   assign bus.stall     = 1'b0;
   assign bus.data_rd_2 = '0;
   assign txd           = txd_q;
   assign rs            = rx_sync_q[1];

   always_comb begin
      bus.data_rd = '0;
      if (bus.read) begin
         if (bus.address[2])
            bus.data_rd = {28'b0, frame_err_q, overrun_q, !rx_empty, !tx_full};
         else if (!rx_empty)
            bus.data_rd = {24'b0, rx_mem_q[rx_rd_ptr_q]};
      end
   end

   // NOTE: FIFO storage has no reset; only pointers and counts define its contents.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.data_wr[7:0];
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_shift_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         tx_count_q  <= '0;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_count_q  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TX_AW'(1);
         if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_AW'(1);
         if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RX_AW'(1);
         if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RX_AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count_q <= tx_count_q + TX_CW'(1);
            2'b01:   tx_count_q <= tx_count_q - TX_CW'(1);
            default: tx_count_q <= tx_count_q;
         endcase
         case ({rx_push, rx_pop})
            2'b10:   rx_count_q <= rx_count_q + RX_CW'(1);
            2'b01:   rx_count_q <= rx_count_q - RX_CW'(1);
            default: rx_count_q <= rx_count_q;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CNT_W'(1);
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         ST_IDLE: begin
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_mem_q[tx_rd_ptr_q];
               tx_state_d = ST_START;
            end
         end
         ST_START: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = ST_DATA;
         end
         ST_DATA: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d   = '0;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
         end
         default: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_mem_q[tx_rd_ptr_q];
               tx_state_d = ST_START;
            end else begin
               tx_state_d = ST_IDLE;
            end
         end
      endcase
   end

   // txd is registered from the current state, so the line lags the FSM by one clock.
   always_comb begin
      case (tx_state_q)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = tx_shift_q[0];
         default:  txd_d = 1'b1;
      endcase
   end

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q + CNT_W'(1);
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_armed_d    = rx_armed_q;
      rx_push_req   = 1'b0;
      set_frame_err = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            if (rs) rx_armed_d = 1'b1;
            else if (rx_armed_q) rx_state_d = ST_START;
         end
         ST_START: if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rs ? ST_IDLE : ST_DATA;
         end
         ST_DATA: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rs, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
         end
         default: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d      = '0;
            rx_state_d    = ST_IDLE;
            rx_armed_d    = rs;
            rx_push_req   = rs;
            set_frame_err = !rs;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q  <= ST_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         txd_q       <= 1'b1;
         rx_sync_q   <= 2'b11;
         rx_state_q  <= ST_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         rx_armed_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         txd_q       <= txd_d;
         rx_sync_q   <= {rx_sync_q[0], rxd};
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_armed_q  <= rx_armed_d;
         overrun_q   <= set_overrun   || (overrun_q   && !status_rd);
         frame_err_q <= set_frame_err || (frame_err_q && !status_rd);
      end
   end

endmodule

// File: tb/tb_uart_controller.sv
// Directed bench for uart_controller at CLK_DIV=4: register vectors, TX framing/back-pressure,
// RX receive, overrun, framing error, glitch rejection and mid-frame reset.
module tb_uart_controller;
   localparam int CLK_DIV = 4;
   localparam int FRAME   = 10 * CLK_DIV;
   localparam logic [31:0] A_DATA   = 32'h0300_0000;
   localparam logic [31:0] A_STATUS = 32'h0300_0004;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] exp_rd;
   } vec_t;

   localparam int NV = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic txd;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   vec_t        vecs [NV];
   logic        tx_pat [10];
   logic [31:0] d;
   logic [7:0]  rx_bytes [17];
   int          lows;

   uart_controller_if bus ();

   uart_controller #(.CLK_DIV(CLK_DIV), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .txd (txd),
      .rxd (rxd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] st(input logic fe, input logic ov, input logic rv, input logic tr);
      return {28'b0, fe, ov, rv, tr};
   endfunction

   task automatic bus_idle();
      bus.read    = 1'b0;
      bus.write   = 1'b0;
      bus.address = '0;
      bus.data_wr = '0;
      bus.mask    = '0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] m);
      bus.address = addr;
      bus.data_wr = data;
      bus.mask    = m;
      bus.write   = 1'b1;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      bus.address = addr;
      bus.read    = 1'b1;
      #1;
      check(name, bus.data_rd, exp);
      @(negedge clk);
      bus_idle();
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (CLK_DIV) @(negedge clk);
   endtask

   task automatic rx_idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic count_lows(input int n, output int l);
      l = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) l++;
      end
   endtask

   // Waits (bounded) for a start bit, then samples each bit in its middle.
   task automatic tx_capture(output logic [7:0] b, output int t_start, output logic ok);
      int w = 0;
      b = '0;
      do begin
         @(negedge clk);
         w++;
      end while (txd !== 1'b0 && w < 400);
      ok      = (txd === 1'b0);
      t_start = cyc;
      repeat (CLK_DIV / 2) @(negedge clk);
      if (txd !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CLK_DIV) @(negedge clk);
         b[i] = txd;
      end
      repeat (CLK_DIV) @(negedge clk);
      if (txd !== 1'b1) ok = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, A_STATUS,     32'h0,  4'h0,    32'h1};
      vecs[1] = '{1'b1, 1'b0, A_DATA,       32'h0,  4'h0,    32'h0};
      vecs[2] = '{1'b0, 1'b1, A_DATA,       32'h55, 4'b1110, 32'h0};
      vecs[3] = '{1'b0, 1'b1, A_STATUS,     32'hFF, 4'hF,    32'h0};
      vecs[4] = '{1'b1, 1'b0, A_STATUS,     32'h0,  4'h0,    32'h1};
      vecs[5] = '{1'b1, 1'b0, 32'h0300_000C, 32'h0, 4'h0,    32'h1};
      vecs[6] = '{1'b1, 1'b0, 32'h0300_0008, 32'h0, 4'h0,    32'h0};
      tx_pat  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      bus_idle();
      repeat (3) @(negedge clk);
      check("reset txd", 32'(txd), 32'h1);
      rst = 1'b0;
      @(negedge clk);

      // Register-level vectors: masked/STATUS writes must not reach the TX FIFO.
      for (int i = 0; i < NV; i++) begin
         bus.read    = vecs[i].rd;
         bus.write   = vecs[i].wr;
         bus.address = vecs[i].addr;
         bus.data_wr = vecs[i].wdata;
         bus.mask    = vecs[i].mask;
         #1;
         check($sformatf("vec%0d data_rd", i), bus.data_rd, vecs[i].exp_rd);
         check($sformatf("vec%0d stall", i), 32'(bus.stall), 32'h0);
         check($sformatf("vec%0d data_rd_2", i), bus.data_rd_2, 32'h0);
         @(negedge clk);
         bus_idle();
      end
      count_lows(20, lows);
      check("ignored writes keep txd idle", 32'(lows), 32'h0);

      // Single byte 0xA5: latency, exact waveform, tx_ready throughout.
      bus_write(A_DATA, 32'hA5, 4'b0001);
      check("t1 txd write+1", 32'(txd), 32'h1);
      @(negedge clk);
      check("t1 txd write+2", 32'(txd), 32'h1);
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < CLK_DIV; c++) begin
            @(negedge clk);
            check($sformatf("t1 bit%0d cyc%0d txd", b, c), 32'(txd), 32'(tx_pat[b]));
            bus.address = A_STATUS;
            bus.read    = 1'b1;
            #1;
            check($sformatf("t1 bit%0d status", b), bus.data_rd, st(0, 0, 0, 1));
         end
      end
      bus_idle();
      @(negedge clk);
      check("t1 txd idle after stop", 32'(txd), 32'h1);

      // Back-to-back writes: 17 fit (one in the shifter), the 18th is dropped.
      fork
         begin
            for (int i = 0; i < 18; i++) bus_write(A_DATA, 32'(i), 4'b0001);
            read_check("t2 status full", A_STATUS, st(0, 0, 0, 0));
         end
         begin
            logic [7:0] b;
            int         t;
            int         t_prev;
            logic       ok;
            t_prev = 0;
            for (int i = 0; i < 17; i++) begin
               tx_capture(b, t, ok);
               check($sformatf("t2 frame%0d ok", i), 32'(ok), 32'h1);
               check($sformatf("t2 frame%0d byte", i), 32'(b), 32'(i));
               if (i > 0) check($sformatf("t2 frame%0d spacing", i), 32'(t - t_prev), 32'(FRAME));
               t_prev = t;
            end
         end
      join
      count_lows(80, lows);
      check("t2 dropped byte not sent", 32'(lows), 32'h0);
      read_check("t2 status drained", A_STATUS, st(0, 0, 0, 1));

      // Single received frame.
      rx_frame(8'h3C, 1'b1);
      rx_idle(6);
      read_check("t3 status valid", A_STATUS, st(0, 0, 1, 1));
      read_check("t3 data", A_DATA, 32'h0000_003C);
      read_check("t3 status empty", A_STATUS, st(0, 0, 0, 1));

      // 17 frames without reading: overrun, first 16 kept in order.
      for (int i = 0; i < 17; i++) begin
         rx_bytes[i] = 8'(i * 37 + 5);
         rx_frame(rx_bytes[i], 1'b1);
         rx_idle(4);
      end
      read_check("t4 status overrun", A_STATUS, st(0, 1, 1, 1));
      read_check("t4 status overrun cleared", A_STATUS, st(0, 0, 1, 1));
      for (int i = 0; i < 16; i++)
         read_check($sformatf("t4 data%0d", i), A_DATA, {24'b0, rx_bytes[i]});
      read_check("t4 status empty", A_STATUS, st(0, 0, 0, 1));

      // Framing error, line held low, then a good frame; then a 1-cycle glitch.
      rx_frame(8'h55, 1'b0);
      rxd = 1'b0;
      repeat (20) @(negedge clk);
      rx_idle(8);
      rx_frame(8'h81, 1'b1);
      rx_idle(6);
      read_check("t5 status frame_err", A_STATUS, st(1, 0, 1, 1));
      read_check("t5 status cleared", A_STATUS, st(0, 0, 1, 1));
      read_check("t5 data", A_DATA, 32'h0000_0081);
      read_check("t5 status empty", A_STATUS, st(0, 0, 0, 1));
      rxd = 1'b0;
      @(negedge clk);
      rx_idle(3 * CLK_DIV);
      read_check("t5 glitch status", A_STATUS, st(0, 0, 0, 1));
      read_check("t5 glitch data", A_DATA, 32'h0);

      // Reset in the middle of a TX frame and an RX frame, with a byte already queued.
      rx_frame(8'h5A, 1'b1);
      rx_idle(6);
      read_check("t6 status before reset", A_STATUS, st(0, 0, 1, 1));
      bus_write(A_DATA, 32'h00, 4'b0001);
      repeat (12) @(negedge clk);
      check("t6 txd low mid-frame", 32'(txd), 32'h0);
      rxd = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6 txd after reset edge", 32'(txd), 32'h1);
      rst = 1'b0;
      count_lows(20, lows);
      check("t6 txd stays idle", 32'(lows), 32'h0);
      rx_idle(10);
      read_check("t6 status after reset", A_STATUS, st(0, 0, 0, 1));
      read_check("t6 data after reset", A_DATA, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
